uart_rx_sampler: RTL and testbench

//  Oversampling UART receiver front end: consumes raw serial line rx_in, syncs it to clk_in,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_sampler.sv | 126 ++++++++++++
 tb/tb_uart_rx_sampler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame geometry.
// Used by the receive sampler and intended for the future transmitter.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 10;
    localparam int unsigned DATA_BITS_DEF    = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronizer for an asynchronous serial line plus falling-edge detect.
// Ports:
//   clk_in    : clock
//   rst       : synchronous active-high reset (chain preset to idle-high)
//   rx_in     : asynchronous serial line
//   rxs       : synchronized line
//   fall_edge : high for one cycle when rxs goes 1 -> 0
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic rx_in,
    output logic rxs,
    output logic fall_edge
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   rxs_d;

    // Preset to 1 so reset release never looks like the line just fell.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            chain <= '1;
            rxs_d <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rx_in};
            rxs_d <= chain[SYNC_STAGES-1];
        end
    end

    assign rxs       = chain[SYNC_STAGES-1];
    assign fall_edge = rxs_d & ~rxs;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: start-bit glitch rejection, mid-bit sampling
// of DATA_BITS LSB-first, stop-bit check, one strobe per frame.
// Ports:
//   clk_in    : clock
//   rst       : synchronous active-high reset
//   rx_in     : asynchronous serial line, idle high
//   rx_data   : last good byte, held until the next good frame
//   rx_valid  : 1-cycle pulse, rx_data new in the same cycle
//   frame_err : 1-cycle pulse, stop bit sampled low (rx_data untouched)
//   busy      : high whenever the receiver is not idle
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    logic                 fall_edge;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .rx_in     (rx_in),
        .rxs       (rxs),
        .fall_edge (fall_edge)
    );

    // Frame FSM; the half-bit wait in START centres all later samples mid-bit.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (fall_edge) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            // line back high by mid-start: treat as a glitch
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxs;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        // return at mid-stop so a back-to-back start is caught
                        cnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (rxs) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int BIT_NS = 200;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       rx_in  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         valid_cycs[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         strobes  = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;
    logic       busy_seen = 1'b0;

    uart_rx_sampler #(
        .CLKS_PER_BIT (10),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected frame.
    always @(negedge clk_in) begin
        exp_t e;
        if (busy) busy_seen = 1'b1;
        if (rx_valid || frame_err) begin
            strobes++;
            if (rx_valid) valid_cycs.push_back(cyc);
            check("exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (prev_strobe) check("strobe_width", 32'd2, 32'd1);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'(strobes), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("kind_err", 32'(frame_err), 32'(e.err));
                check("data", 32'(rx_data), 32'(e.data));
            end
        end
        prev_strobe = rx_valid | frame_err;
    end

    // Drive one frame at the bit rate and queue the outcome it should produce.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : last_good;
        if (stop) last_good = d;
        sb_q.push_back(e);
        rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            #(BIT_NS);
        end
        rx_in = stop;
        #(BIT_NS);
        rx_in = 1'b1;
    endtask

    initial begin
        int n0;
        int t0;
        int s0;

        // 1: reset with idle line
        rst   = 1'b1;
        rx_in = 1'b1;
        #40;
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #2000;
        check("idle_strobes", 32'(strobes), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // 3: 50 ns glitch, offset so its edges fall between clock edges
        busy_seen = 1'b0;
        #5;
        rx_in = 1'b0;
        #50;
        rx_in = 1'b1;
        #15;
        #400;
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_strobes", 32'(strobes), 32'd0);

        // 2: frame 0x55 with latency window
        n0 = valid_cycs.size();
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        #400;
        check("f55_count", 32'(valid_cycs.size() - n0), 32'd1);
        if (valid_cycs.size() > n0)
            check("f55_latency_ok",
                  32'((valid_cycs[n0] - t0) >= 95 && (valid_cycs[n0] - t0) <= 100), 32'd1);
        check("f55_hold", 32'(rx_data), 32'h55);

        // 4: 0xA3 with low stop bit, line then returns high
        n0 = valid_cycs.size();
        s0 = strobes;
        send_frame(8'hA3, 1'b0);
        #400;
        check("fa3_strobes", 32'(strobes - s0), 32'd1);
        check("fa3_no_valid", 32'(valid_cycs.size() - n0), 32'd0);
        check("fa3_data_kept", 32'(rx_data), 32'h55);
        check("fa3_idle", 32'(busy), 32'd0);

        // 5: back-to-back, no idle bit between frames
        n0 = valid_cycs.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        #400;
        check("b2b_count", 32'(valid_cycs.size() - n0), 32'd2);
        if (valid_cycs.size() >= n0 + 2)
            check("b2b_gap", 32'(valid_cycs[n0 + 1] - valid_cycs[n0]), 32'd100);

        // 6: reset mid-DATA (after bit 3) then a clean 0x3C
        s0 = strobes;
        rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_in = 1'b1;
            #(BIT_NS);
        end
        rx_in = 1'b0;
        #(BIT_NS / 2);
        rst   = 1'b1;
        rx_in = 1'b1;
        #40;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_clr", 32'(rx_data), 32'd0);
        rst = 1'b0;
        #400;
        check("abort_no_strobe", 32'(strobes - s0), 32'd0);
        send_frame(8'h3C, 1'b1);
        #400;
        check("f3c_data", 32'(rx_data), 32'h3C);
        check("f3c_strobes", 32'(strobes - s0), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
